// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, request record, LFSR helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      DR_IDLE = 2'd0,
      DR_WAIT = 2'd1,
      DR_RESP = 2'd2
   } dmem_resp_state_e;

   // Request captured at the accept edge; everything after acceptance works from this copy
   typedef struct packed {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } dmem_req_t;

   // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
   localparam logic [15:0] DMEM_LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] dmem_lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? DMEM_LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/dmem_responder_lat_lfsr.sv
// lat_lfsr: 16-bit Galois LFSR supplying pseudo-random response latencies.
// Latency: state advances on the edge where i_advance is high.
// Backpressure: none; holds its value while i_advance is low.
module dmem_responder_lat_lfsr
   import dmem_responder_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_advance,
   output logic [15:0] o_state
);

   logic [15:0] r_lfsr;

   // Step the sequence once per accepted request; a nonzero seed keeps it off the lock-up state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= SEED;
      end else if (i_advance) begin
         r_lfsr <= dmem_lfsr_next(r_lfsr);
      end
   end

   assign o_state = r_lfsr;

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU data-memory port: word RAM with byte-lane write masking.
// Latency: response pulse in the cycle after edge (accept + latency); LATENCY, or random 1..MAX_LAT with DMEM_LFSR_LAT_EN.
// Backpressure: requests are level-held by the initiator; only accepted in IDLE, at least one idle cycle between ops.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 2
`ifdef DMEM_LFSR_LAT_EN
   ,
   parameter int unsigned MAX_LAT   = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_dmem_address,
   input  logic        i_dmem_read,
   input  logic        i_dmem_write,
   input  logic [31:0] i_dmem_wdata,
   input  logic [3:0]  i_dmem_wmask,
   output logic        o_dmem_resp,
   output logic [31:0] o_dmem_rdata,
   output logic        o_busy,
   output logic        o_err
);

`ifdef DMEM_LFSR_LAT_EN
   localparam int unsigned LAT_TOP = (MAX_LAT > LATENCY) ? MAX_LAT : LATENCY;
`else
   localparam int unsigned LAT_TOP = LATENCY;
`endif
   localparam int unsigned CNT_W = $clog2(LAT_TOP + 1);

   dmem_resp_state_e r_state;
   dmem_req_t        r_req;
   logic [CNT_W-1:0] r_cnt;
   logic             r_resp;
   logic [31:0]      r_rdata;
   logic             r_err;
   logic [31:0]      r_mem [2**ADDR_W];

   logic             w_accept;
   logic             w_in_range_req;
   logic             w_in_range_in;
   logic [ADDR_W-1:0] w_idx;
   logic [CNT_W-1:0] w_lat;
   logic             w_addr_lsb_unused;

   assign w_accept       = (r_state == DR_IDLE) && (i_dmem_read || i_dmem_write);
   assign w_in_range_in  = (i_dmem_address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign w_in_range_req = (r_req.addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign w_idx          = r_req.addr[ADDR_W+1:2];
   // Byte-offset bits are carried in the request record but never steer anything
   assign w_addr_lsb_unused = ^r_req.addr[1:0];

`ifdef DMEM_LFSR_LAT_EN
   logic [15:0] w_lfsr;
   logic        w_lfsr_hi_unused;

   dmem_responder_lat_lfsr #(
      .SEED      (LFSR_SEED)
   ) u_lat_lfsr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_advance (w_accept),
      .o_state   (w_lfsr)
   );

   // Latency is drawn from the LFSR value present at the accept edge
   assign w_lat            = CNT_W'(32'(w_lfsr[7:0]) % MAX_LAT + 32'd1);
   assign w_lfsr_hi_unused = ^w_lfsr[15:8];
`else
   assign w_lat = CNT_W'(LATENCY);
`endif

   // Transaction FSM: accept in IDLE, count down in WAIT, one-cycle response in RESP
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= DR_IDLE;
         r_req   <= '0;
         r_cnt   <= '0;
         r_resp  <= 1'b0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_resp <= 1'b0;
         case (r_state)
            DR_IDLE: begin
               if (w_accept) begin
                  // Simultaneous read and write is served as a read only
                  r_req.addr  <= i_dmem_address;
                  r_req.rd    <= i_dmem_read;
                  r_req.wr    <= i_dmem_write && !i_dmem_read;
                  r_req.wdata <= i_dmem_wdata;
                  r_req.wmask <= i_dmem_wmask;
                  // Counting from the full latency puts the response after edge accept+latency
                  r_cnt   <= w_lat;
                  r_state <= DR_WAIT;
                  if (!w_in_range_in || (i_dmem_read && i_dmem_write)) begin
                     r_err <= 1'b1;
                  end
               end
            end
            DR_WAIT: begin
               if (r_cnt <= CNT_W'(1)) begin
                  r_state <= DR_RESP;
                  r_resp  <= 1'b1;
                  if (r_req.rd) begin
                     r_rdata <= w_in_range_req ? r_mem[w_idx] : 32'h0;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DR_RESP: begin
               r_state <= DR_IDLE;
            end
            default: begin
               r_state <= DR_IDLE;
            end
         endcase
      end
   end

   // Write commit on the edge leaving RESP; reset forces IDLE first, so an abandoned op never commits
   always_ff @(posedge i_clk) begin
      if (r_state == DR_RESP && r_req.wr && w_in_range_req) begin
         for (int b = 0; b < 4; b++) begin
            if (r_req.wmask[b]) begin
               r_mem[w_idx][8*b +: 8] <= r_req.wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_dmem_resp  = r_resp;
   assign o_dmem_rdata = r_rdata;
   assign o_busy       = (r_state != DR_IDLE);
   assign o_err        = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, byte masking, range/collision errors, hold and reset.
// Latency: expects the response after edge accept+2 in the default build, 1..8 with DMEM_LFSR_LAT_EN.
// Backpressure: requests are held level until the response, as the CPU memory stage does.
module tb_dmem_responder;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        resp;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   int n_checks;
   int n_errors;
   int resp_count;

   dmem_responder u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_dmem_address (addr),
      .i_dmem_read    (rd),
      .i_dmem_write   (wr),
      .i_dmem_wdata   (wdata),
      .i_dmem_wmask   (wmask),
      .o_dmem_resp    (resp),
      .o_dmem_rdata   (rdata),
      .o_busy         (busy),
      .o_err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tally response pulses as they are seen at the edge that ends them
   always @(posedge clk) begin
      if (resp) resp_count <= resp_count + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_lat(input string tag, input int lat);
`ifdef DMEM_LFSR_LAT_EN
      check(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
      check(tag, 32'(lat), 32'd2);
`endif
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wmask = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction: present at a negedge in IDLE, accept at the next posedge, count edges to resp
   task automatic do_op(input logic op_rd, input logic op_wr, input logic [31:0] op_addr,
                        input logic [31:0] op_wdata, input logic [3:0] op_mask, input bit hold,
                        output logic [31:0] got_rdata, output int lat);
      @(negedge clk);
      rd = op_rd; wr = op_wr; addr = op_addr; wdata = op_wdata; wmask = op_mask;
      @(posedge clk);
      #1;
      lat = 0;
      while (!resp && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      got_rdata = rdata;
      @(posedge clk);
      #1;
      if (!hold) begin
         rd = 1'b0; wr = 1'b0;
      end
   endtask

   logic [31:0] d;
   int          lat;

   initial begin
      n_checks = 0; n_errors = 0; resp_count = 0;
      rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wmask = '0;
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_resp",  32'(resp),  32'd0);
      check("rst_rdata", rdata,      32'h0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_err",   32'(err),   32'd0);

      // Full-word store then load
      do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, d, lat);
      chk_lat("sw_lat", lat);
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, d, lat);
      chk_lat("lw_lat", lat);
      check("lw_data", d, 32'hDEAD_BEEF);
      check("lw_err", 32'(err), 32'd0);

      // Single-lane write merges into the existing word
      do_op(1'b0, 1'b1, 32'h14, 32'h1122_3344, 4'b1111, 1'b0, d, lat);
      check("sw_keeps_rdata", d, 32'hDEAD_BEEF);
      do_op(1'b0, 1'b1, 32'h14, 32'hAB00_0000, 4'b1000, 1'b0, d, lat);
      do_op(1'b1, 1'b0, 32'h14, 32'h0, 4'b0000, 1'b0, d, lat);
      check("sb_lane3", d, 32'hAB22_3344);
      do_op(1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0000, 1'b0, d, lat);
      chk_lat("mask0_lat", lat);
      do_op(1'b1, 1'b0, 32'h14, 32'h0, 4'b0000, 1'b0, d, lat);
      check("mask0_nochg", d, 32'hAB22_3344);

      // Out-of-range read and write
      do_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 1'b0, d, lat);
      chk_lat("oor_lat", lat);
      check("oor_rdata", d, 32'h0);
      check("oor_err", 32'(err), 32'd1);
      do_op(1'b0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b1111, 1'b0, d, lat);
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, d, lat);
      check("oor_wr_dropped", d, 32'hDEAD_BEEF);

      // Reset clears err and rdata but keeps RAM; read+write together is a read plus error
      apply_reset();
      check("rst2_err", 32'(err), 32'd0);
      check("rst2_rdata", rdata, 32'h0);
      do_op(1'b1, 1'b1, 32'h10, 32'h0000_0000, 4'b1111, 1'b0, d, lat);
      check("rdwr_data", d, 32'hDEAD_BEEF);
      check("rdwr_err", 32'(err), 32'd1);
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, d, lat);
      check("rdwr_ram_kept", d, 32'hDEAD_BEEF);

      // Request held across the response: one resp per op, re-accept after one idle cycle
      apply_reset();
      resp_count = 0;
      do_op(1'b1, 1'b0, 32'h14, 32'h0, 4'b0000, 1'b1, d, lat);
      check("hold_idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("hold_reaccept_busy", 32'(busy), 32'd1);
      lat = 0;
      while (!resp && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk_lat("hold_lat2", lat);
      check("hold_data2", rdata, 32'hAB22_3344);
      @(posedge clk);
      #1;
      rd = 1'b0;
      check("hold_resp_count", 32'(resp_count), 32'd2);

      // Reset while waiting abandons the write
      @(negedge clk);
      resp_count = 0;
      wr = 1'b1; addr = 32'h10; wdata = 32'h0BAD_F00D; wmask = 4'b1111;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstwait_busy", 32'(busy), 32'd0);
      wr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rstwait_no_resp", 32'(resp_count), 32'd0);
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, d, lat);
      check("rstwait_no_commit", d, 32'hDEAD_BEEF);

`ifdef DMEM_LFSR_LAT_EN
      begin
         int          bad_lat;
         int          bad_data;
         logic [7:0]  hit;
         bad_lat = 0; bad_data = 0; hit = 8'h00;
         for (int i = 0; i < 1000; i++) begin
            do_op(1'b1, 1'b0, 32'h14, 32'h0, 4'b0000, 1'b0, d, lat);
            if (lat < 1 || lat > 8) bad_lat++;
            else hit[lat-1] = 1'b1;
            if (d !== 32'hAB22_3344) bad_data++;
         end
         check("lfsr_lat_range", 32'(bad_lat), 32'd0);
         check("lfsr_all_hit", {24'h0, hit}, 32'h0000_00FF);
         check("lfsr_data", 32'(bad_data), 32'd0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
